// File: rtl/updown_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter_pkg
// Brief    : Direction and mode encodings shared by the up/down modulo counter.
// Revision : 1.0 - initial release
// ============================================================================
package updown_mod_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DN    = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage : updown_mod_counter_pkg
`default_nettype wire

// File: rtl/updown_mod_counter_sat_incr.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter_sat_incr
// Brief    : Combinational saturating incrementer with clear (clear wins).
// Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter_sat_incr #(
   parameter int WRAP_W = 8
) (
   input  logic              clr_i,
   input  logic              inc_i,
   input  logic [WRAP_W-1:0] val_i,
   output logic [WRAP_W-1:0] nxt_o
);

   logic w_at_max;

   assign w_at_max = (val_i == {WRAP_W{1'b1}});

   always_comb begin
      nxt_o = val_i;
      if (clr_i) begin
         nxt_o = '0;
      end else if (inc_i && !w_at_max) begin
         nxt_o = val_i + WRAP_W'(1);
      end
   end

endmodule : updown_mod_counter_sat_incr
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter
// Brief    : Up/down counter over 0..mod_max with load, wrap/saturate mode,
//            registered terminal-count pulse and saturating wrap-event count.
// Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter
   import updown_mod_counter_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              en,
   input  logic              up,
   input  logic              sat,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic [WIDTH-1:0]  mod_max,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              at_bound,
   output logic [WRAP_W-1:0] wrap_cnt
);

   logic [WIDTH-1:0]  count_q, count_d;
   logic              tc_q, tc_d;
   logic              at_bound_q, at_bound_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic              wrap_inc, wrap_clr;

   always_comb begin
      count_d    = count_q;
      tc_d       = 1'b0;
      at_bound_d = 1'b0;
      wrap_inc   = 1'b0;
      wrap_clr   = 1'b0;
      if (load) begin
         count_d  = (load_val > mod_max) ? mod_max : load_val;
         wrap_clr = 1'b1;
      end else if (en) begin
         case (up)
            DIR_UP: begin
               // ">=" so a count left above a freshly lowered mod_max still wraps
               if (count_q < mod_max) begin
                  count_d = count_q + WIDTH'(1);
               end else if (sat == MODE_SAT) begin
                  at_bound_d = 1'b1;
               end else begin
                  count_d  = '0;
                  tc_d     = 1'b1;
                  wrap_inc = 1'b1;
               end
            end
            DIR_DN: begin
               if (count_q != '0) begin
                  count_d = count_q - WIDTH'(1);
               end else if (sat == MODE_SAT) begin
                  at_bound_d = 1'b1;
               end else begin
                  count_d  = mod_max;
                  tc_d     = 1'b1;
                  wrap_inc = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   updown_mod_counter_sat_incr #(
      .WRAP_W (WRAP_W)
   ) u_wrap_incr (
      .clr_i (wrap_clr),
      .inc_i (wrap_inc),
      .val_i (wrap_q),
      .nxt_o (wrap_d)
   );

   always_ff @(posedge clk1) begin
      if (rst) begin
         count_q    <= '0;
         tc_q       <= 1'b0;
         at_bound_q <= 1'b0;
         wrap_q     <= '0;
      end else begin
         count_q    <= count_d;
         tc_q       <= tc_d;
         at_bound_q <= at_bound_d;
         wrap_q     <= wrap_d;
      end
   end

   assign count    = count_q;
   assign tc       = tc_q;
   assign at_bound = at_bound_q;
   assign wrap_cnt = wrap_q;

endmodule : updown_mod_counter
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_mod_counter
// Brief    : Self-checking bench with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

   localparam int WIDTH  = 4;
   localparam int WRAP_W = 3;
   localparam int WMAX   = (1 << WRAP_W) - 1;

   logic              clk1 = 1'b0;
   logic              rst, en, up, sat, load;
   logic [WIDTH-1:0]  load_val, mod_max;
   logic [WIDTH-1:0]  count;
   logic              tc, at_bound;
   logic [WRAP_W-1:0] wrap_cnt;

   int total = 0;
   int bad   = 0;

   int m_count, m_tc, m_ab, m_wrap;

   updown_mod_counter #(
      .WIDTH  (WIDTH),
      .WRAP_W (WRAP_W)
   ) dut (
      .clk1     (clk1),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .sat      (sat),
      .load     (load),
      .load_val (load_val),
      .mod_max  (mod_max),
      .count    (count),
      .tc       (tc),
      .at_bound (at_bound),
      .wrap_cnt (wrap_cnt)
   );

   always #5 clk1 = ~clk1;

   // Reference: counter value kept as a plain integer on the range 0..mod_max
   task automatic model_update();
      int mm;
      int lv;
      mm = int'(mod_max);
      lv = int'(load_val);
      m_tc = 0;
      m_ab = 0;
      if (rst) begin
         m_count = 0;
         m_wrap  = 0;
      end else if (load) begin
         m_count = (lv < mm) ? lv : mm;
         m_wrap  = 0;
      end else if (en) begin
         if (up) begin
            if (m_count < mm) m_count = m_count + 1;
            else if (sat) m_ab = 1;
            else begin
               m_count = 0;
               m_tc    = 1;
               m_wrap  = (m_wrap < WMAX) ? m_wrap + 1 : WMAX;
            end
         end else begin
            if (m_count > 0) m_count = m_count - 1;
            else if (sat) m_ab = 1;
            else begin
               m_count = mm;
               m_tc    = 1;
               m_wrap  = (m_wrap < WMAX) ? m_wrap + 1 : WMAX;
            end
         end
      end
   endtask

   task automatic tick();
      model_update();
      @(posedge clk1);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b0;
      load_val = 4'd9; mod_max = 4'd15;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({count, tc, at_bound, wrap_cnt} !== '0) begin
            bad++;
            $display("FAIL reset[%0d]: count=%0d tc=%0d ab=%0d wrap=%0d, expected all zero",
                     i, count, tc, at_bound, wrap_cnt);
         end
      end
   endtask

   task automatic test_up_wrap();
      rst = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0; mod_max = 4'd15;
      for (int i = 0; i < 16; i++) begin
         tick();
         total++;
         if (count !== WIDTH'((i + 1) % 16) || tc !== (i == 15)) begin
            bad++;
            $display("FAIL up_wrap[%0d]: count=%0d tc=%0d, expected count=%0d tc=%0d",
                     i, count, tc, (i + 1) % 16, (i == 15));
         end
      end
   endtask

   task automatic test_down_wrap();
      int seq [5] = '{2, 1, 0, 9, 8};
      mod_max = 4'd9; up = 1'b0; sat = 1'b0; load_val = 4'd2; load = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         load = 1'b0;
         total++;
         if (count !== WIDTH'(seq[i]) || tc !== (i == 3) || at_bound !== 1'b0) begin
            bad++;
            $display("FAIL down_wrap[%0d]: count=%0d tc=%0d ab=%0d, expected count=%0d tc=%0d ab=0",
                     i, count, tc, at_bound, seq[i], (i == 3));
         end
      end
   endtask

   task automatic test_sat_hold();
      int seq [5] = '{4, 5, 5, 5, 4};
      int ab  [5] = '{0, 0, 1, 1, 0};
      sat = 1'b1; up = 1'b1; mod_max = 4'd5; load_val = 4'd4; load = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         load = 1'b0;
         if (i == 3) up = 1'b0;
         total++;
         if (count !== WIDTH'(seq[i]) || at_bound !== ab[i][0] || tc !== 1'b0) begin
            bad++;
            $display("FAIL sat_hold[%0d]: count=%0d ab=%0d tc=%0d, expected count=%0d ab=%0d tc=0",
                     i, count, at_bound, tc, seq[i], ab[i]);
         end
      end
   endtask

   task automatic test_load_clamp();
      sat = 1'b0; up = 1'b1; load_val = 4'd12; mod_max = 4'd7; load = 1'b1;
      tick();
      load = 1'b0;
      total++;
      if (count !== 4'd7 || wrap_cnt !== '0) begin
         bad++;
         $display("FAIL load_clamp: count=%0d wrap=%0d, expected count=7 wrap=0", count, wrap_cnt);
      end
      mod_max = 4'd3;
      tick();
      total++;
      if (count !== 4'd0 || tc !== 1'b1 || wrap_cnt !== 3'd1) begin
         bad++;
         $display("FAIL shrink_mod: count=%0d tc=%0d wrap=%0d, expected count=0 tc=1 wrap=1",
                  count, tc, wrap_cnt);
      end
   endtask

   task automatic test_wrap_cnt_sat();
      mod_max = 4'd1; sat = 1'b0; up = 1'b1; load_val = 4'd0; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if (wrap_cnt !== WRAP_W'(m_wrap) || count !== WIDTH'(m_count) || tc !== m_tc[0]) begin
            bad++;
            $display("FAIL wrap_cnt[%0d]: count=%0d tc=%0d wrap=%0d, expected count=%0d tc=%0d wrap=%0d",
                     i, count, tc, wrap_cnt, m_count, m_tc, m_wrap);
         end
      end
      total++;
      if (wrap_cnt !== 3'd7) begin
         bad++;
         $display("FAIL wrap_cnt_held: wrap=%0d, expected 7", wrap_cnt);
      end
      load = 1'b1; load_val = 4'd0;
      tick();
      load = 1'b0;
      total++;
      if (wrap_cnt !== 3'd0 || count !== 4'd0) begin
         bad++;
         $display("FAIL wrap_cnt_clear: wrap=%0d count=%0d, expected wrap=0 count=0", wrap_cnt, count);
      end
   endtask

   task automatic test_rst_priority();
      mod_max = 4'd15; load_val = 4'd6; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      rst = 1'b1; load = 1'b1; load_val = 4'd11;
      tick();
      rst = 1'b0; load = 1'b0;
      total++;
      if (count !== 4'd0 || wrap_cnt !== 3'd0 || tc !== 1'b0 || at_bound !== 1'b0) begin
         bad++;
         $display("FAIL rst_priority: count=%0d wrap=%0d tc=%0d ab=%0d, expected all zero",
                  count, wrap_cnt, tc, at_bound);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 49) == 0);
         load     = ($urandom_range(0, 9) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up       = $urandom_range(0, 1) == 1;
         sat      = ($urandom_range(0, 3) == 0);
         load_val = WIDTH'($urandom);
         if ($urandom_range(0, 15) == 0) mod_max = WIDTH'($urandom);
         tick();
         total++;
         if ({count, tc, at_bound, wrap_cnt} !==
             {WIDTH'(m_count), m_tc[0], m_ab[0], WRAP_W'(m_wrap)}) begin
            bad++;
            $display("FAIL random[%0d]: count=%0d tc=%0d ab=%0d wrap=%0d, expected count=%0d tc=%0d ab=%0d wrap=%0d",
                     i, count, tc, at_bound, wrap_cnt, m_count, m_tc, m_ab, m_wrap);
         end
      end
   endtask

   initial begin
      m_count = 0; m_tc = 0; m_ab = 0; m_wrap = 0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_sat_hold();
      test_load_clamp();
      test_wrap_cnt_sat();
      test_rst_priority();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_updown_mod_counter
`default_nettype wire
